// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the instruction/data cache memory arbiter:
//   - state_t          : arbiter FSM states
//   - ADDR_W_DEF       : default memory line address width
//   - LINE_W_DEF       : default cache line width
//   - GRANT_I/GRANT_D  : encodings of the 1-bit grant / last_grant value
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = 128;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundle of every handshake/data signal around the arbiter.
//   I-cache side : i_read, i_addr -> arbiter ; i_rdata, i_ready <- arbiter
//   D-cache side : d_read, d_write, d_addr, d_wdata -> arbiter ;
//                  d_rdata, d_ready <- arbiter
//   Memory side  : mem_read, mem_write, mem_addr, mem_wdata <- arbiter ;
//                  mem_rdata, mem_ready -> arbiter
// Modports:
//   slave  : the arbiter's view (serves the caches, drives memory commands)
//   master : the environment's view (caches plus memory)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
  parameter int LINE_W = mem_arb_pkg::LINE_W_DEF
);

  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_ready;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  i_read, i_addr,
    output i_rdata, i_ready,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output i_read, i_addr,
    input  i_rdata, i_ready,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one line-wide memory port between an I-cache (fills only) and a
// D-cache (fills and write-backs). One transaction is in flight at a time;
// simultaneous requests alternate round-robin, starting with the I side
// after reset.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : mem_arbiter_if.slave carrying the I-cache, D-cache and memory
//         signals
// Memory command, address and write data come straight from registers
// captured at grant time, so they stay stable for the whole transaction
// even if the requester changes or drops its inputs.
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  state_t            state_q,      state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q,   mem_read_d;
  logic              mem_write_q,  mem_write_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [LINE_W-1:0] wdata_q,      wdata_d;
  logic [LINE_W-1:0] i_rdata_q,    i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q,    d_rdata_d;

  logic i_req;
  logic d_req;
  logic pick_i;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  // On a tie, the side that did not complete last wins.
  assign pick_i = i_req & (~d_req | (last_grant_q == GRANT_D));

  // Next-state logic. last_grant is updated at completion, so in DONE it
  // also identifies which side gets the completion pulse.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (pick_i) begin
          state_d     = I_BUSY;
          addr_d      = bus.i_addr;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
        end else if (d_req) begin
          // A simultaneous read and write from the D side is a write-back.
          state_d     = D_BUSY;
          addr_d      = bus.d_addr;
          wdata_d     = bus.d_wdata;
          mem_read_d  = ~bus.d_write;
          mem_write_d = bus.d_write;
        end
      end

      I_BUSY: begin
        if (bus.mem_ready) begin
          state_d      = DONE;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          last_grant_d = GRANT_I;
          i_rdata_d    = bus.mem_rdata;
        end
      end

      D_BUSY: begin
        if (bus.mem_ready) begin
          state_d      = DONE;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          last_grant_d = GRANT_D;
          if (mem_read_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_ready   = (state_q == DONE) && (last_grant_q == GRANT_I);
  assign bus.d_ready   = (state_q == DONE) && (last_grant_q == GRANT_D);

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter: a small memory model answers commands
// after a programmable number of cycles, and a monitor counts command
// cycles, completion pulses and grant order.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 28;
  localparam int LW = 128;

  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory model controls
  bit          memAuto = 1'b1;
  int          memLat  = 1;
  logic [LW-1:0] memData = '0;
  int          memCnt  = 0;

  // Monitor state
  int          cyc = 0;
  int          rdCycles, wrCycles, bothCycles, iPulses, dPulses;
  logic [AW-1:0] seenAddr;
  logic [LW-1:0] seenWdata, iData, dData;
  logic        prevCmd = 1'b0;
  logic [AW-1:0] grantAddr[$];
  int          grantCyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model and monitor, both evaluated on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (memAuto) begin
      if (bus.mem_read || bus.mem_write) begin
        memCnt = memCnt + 1;
        bus.mem_ready = (memCnt == memLat);
        bus.mem_rdata = (memCnt == memLat) ? memData : '0;
      end else begin
        memCnt = 0;
        bus.mem_ready = 1'b0;
      end
    end
    if (bus.mem_read) rdCycles = rdCycles + 1;
    if (bus.mem_write) wrCycles = wrCycles + 1;
    if (bus.mem_read && bus.mem_write) bothCycles = bothCycles + 1;
    if (bus.mem_read || bus.mem_write) begin
      seenAddr  = bus.mem_addr;
      seenWdata = bus.mem_wdata;
      if (!prevCmd) begin
        grantAddr.push_back(bus.mem_addr);
        grantCyc.push_back(cyc);
      end
    end
    prevCmd = bus.mem_read | bus.mem_write;
    if (bus.i_ready) begin
      iPulses = iPulses + 1;
      iData   = bus.i_rdata;
    end
    if (bus.d_ready) begin
      dPulses = dPulses + 1;
      dData   = bus.d_rdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                             input logic [LW-1:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iRd, input logic [AW-1:0] iAddr,
                               input logic dRd, input logic dWr,
                               input logic [AW-1:0] dAddr,
                               input logic [LW-1:0] dWdata);
    bus.i_read  = iRd;
    bus.i_addr  = iAddr;
    bus.d_read  = dRd;
    bus.d_write = dWr;
    bus.d_addr  = dAddr;
    bus.d_wdata = dWdata;
  endtask

  task automatic nextCycle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clearMon();
    rdCycles = 0; wrCycles = 0; bothCycles = 0;
    iPulses = 0; dPulses = 0;
    seenAddr = '0; seenWdata = '0; iData = '0; dData = '0;
    grantAddr.delete();
    grantCyc.delete();
  endtask

  // Wait until the total completion count reaches want, then drop all
  // requests while the arbiter is still in DONE.
  task automatic waitPulses(input string tag, input int want, input int budget);
    int n;
    n = 0;
    while ((iPulses + dPulses) < want && n < budget) begin
      nextCycle(1);
      n = n + 1;
    end
    if ((iPulses + dPulses) < want)
      checkOutput({tag, "_timeout"}, LW'(iPulses + dPulses), LW'(want));
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic doReset();
    rst = 1'b0;
    nextCycle(2);
    rst = 1'b1;
    nextCycle(1);
  endtask

  localparam logic [LW-1:0] I_DATA = 128'h1111_2222_3333_4444_5555_6666_7777_1234;
  localparam logic [LW-1:0] D_DATA = 128'hDDDD_0000_0000_0000_0000_0000_0000_5A5A;

  initial begin
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    clearMon();
    nextCycle(2);

    // Outputs while held in reset
    checkOutput("rst_mem_read",  LW'(bus.mem_read),  '0);
    checkOutput("rst_mem_write", LW'(bus.mem_write), '0);
    checkOutput("rst_mem_addr",  LW'(bus.mem_addr),  '0);
    checkOutput("rst_mem_wdata", bus.mem_wdata,      '0);
    checkOutput("rst_i_ready",   LW'(bus.i_ready),   '0);
    checkOutput("rst_d_ready",   LW'(bus.d_ready),   '0);
    checkOutput("rst_i_rdata",   bus.i_rdata,        '0);
    checkOutput("rst_d_rdata",   bus.d_rdata,        '0);
    rst = 1'b1;
    nextCycle(1);

    // I-side fill, memory answers on the third command cycle
    clearMon();
    memLat = 3; memData = I_DATA;
    applyStimulus(1'b1, 28'h0000010, 1'b0, 1'b0, '0, '0);
    waitPulses("i_fill", 1, 20);
    checkOutput("i_fill_rd_cycles", LW'(rdCycles), LW'(3));
    checkOutput("i_fill_wr_cycles", LW'(wrCycles), '0);
    checkOutput("i_fill_addr",      LW'(seenAddr), LW'(28'h10));
    checkOutput("i_fill_data",      iData,         I_DATA);
    nextCycle(3);
    checkOutput("i_fill_pulses",    LW'(iPulses),  LW'(1));
    checkOutput("i_fill_d_pulses",  LW'(dPulses),  '0);
    checkOutput("i_fill_hold",      bus.i_rdata,   I_DATA);

    // D-side fill, then a write-back that must leave d_rdata alone
    clearMon();
    memLat = 2; memData = D_DATA;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 28'h0000030, '0);
    waitPulses("d_fill", 1, 20);
    checkOutput("d_fill_data",      dData,         D_DATA);
    checkOutput("d_fill_addr",      LW'(seenAddr), LW'(28'h30));
    nextCycle(1);
    clearMon();
    memData = '1;
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 28'h0000020, 128'hABCD);
    waitPulses("d_wr", 1, 20);
    nextCycle(2);
    checkOutput("d_wr_wr_cycles",   LW'(wrCycles),  LW'(2));
    checkOutput("d_wr_rd_cycles",   LW'(rdCycles),  '0);
    checkOutput("d_wr_addr",        LW'(seenAddr),  LW'(28'h20));
    checkOutput("d_wr_wdata",       seenWdata,      128'hABCD);
    checkOutput("d_wr_pulses",      LW'(dPulses),   LW'(1));
    checkOutput("d_wr_rdata_keep",  bus.d_rdata,    D_DATA);

    // d_read and d_write together become a write
    clearMon();
    memLat = 1;
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 28'h0000044, 128'h77);
    waitPulses("d_rw", 1, 20);
    nextCycle(2);
    checkOutput("d_rw_wr_cycles",   LW'(wrCycles),   LW'(1));
    checkOutput("d_rw_rd_cycles",   LW'(rdCycles),   '0);
    checkOutput("d_rw_both",        LW'(bothCycles), '0);
    checkOutput("d_rw_rdata_keep",  bus.d_rdata,     D_DATA);

    // Tie after reset: I, D, I, D with both requests held
    doReset();
    clearMon();
    memLat = 1;
    applyStimulus(1'b1, 28'h0000100, 1'b1, 1'b0, 28'h0000200, '0);
    waitPulses("tie", 4, 60);
    nextCycle(3);
    checkOutput("tie_grants",  LW'(grantAddr.size()), LW'(4));
    checkOutput("tie_i_pulses", LW'(iPulses), LW'(2));
    checkOutput("tie_d_pulses", LW'(dPulses), LW'(2));
    if (grantAddr.size() == 4) begin
      checkOutput("tie_g0", LW'(grantAddr[0]), LW'(28'h100));
      checkOutput("tie_g1", LW'(grantAddr[1]), LW'(28'h200));
      checkOutput("tie_g2", LW'(grantAddr[2]), LW'(28'h100));
      checkOutput("tie_g3", LW'(grantAddr[3]), LW'(28'h200));
    end

    // Reset while D_BUSY waits for memory
    clearMon();
    memAuto = 1'b0;
    bus.mem_ready = 1'b0;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 28'h0000040, '0);
    nextCycle(3);
    checkOutput("rstmid_busy_rd", LW'(bus.mem_read), LW'(1));
    checkOutput("rstmid_busy_addr", LW'(bus.mem_addr), LW'(28'h40));
    rst = 1'b0;
    #1;
    checkOutput("rstmid_rd",     LW'(bus.mem_read), '0);
    checkOutput("rstmid_addr",   LW'(bus.mem_addr), '0);
    checkOutput("rstmid_rdata",  bus.d_rdata,       '0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    nextCycle(1);
    rst = 1'b1;
    nextCycle(1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'hBAD;
    nextCycle(2);
    bus.mem_ready = 1'b0;
    nextCycle(3);
    checkOutput("rstmid_no_pulse", LW'(dPulses),     '0);
    checkOutput("rstmid_idle_rd",  LW'(bus.mem_read), '0);
    checkOutput("rstmid_rdata_z",  bus.d_rdata,       '0);
    memAuto = 1'b1;

    // Back-to-back I fills with single-cycle memory
    clearMon();
    memLat = 1; memData = I_DATA;
    applyStimulus(1'b1, 28'h0000300, 1'b0, 1'b0, '0, '0);
    waitPulses("b2b", 3, 30);
    nextCycle(4);
    checkOutput("b2b_pulses", LW'(iPulses), LW'(3));
    checkOutput("b2b_grants", LW'(grantAddr.size()), LW'(3));
    if (grantCyc.size() == 3) begin
      checkOutput("b2b_gap1", LW'(grantCyc[1] - grantCyc[0]), LW'(3));
      checkOutput("b2b_gap2", LW'(grantCyc[2] - grantCyc[1]), LW'(3));
    end
    checkOutput("b2b_rd_cycles", LW'(rdCycles), LW'(3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute watchdog so a stuck run still terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, memory line address width in bits.
REQ-002 Parameter LINE_W, default 128, line data width in bits.
REQ-003 clk  input  1  clock, all state updated on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 i_read  input  1  I-cache line-fill request, held high until i_ready.
REQ-006 i_addr  input  ADDR_W  I-cache line address.
REQ-007 i_rdata  output  LINE_W  I-cache fill data, valid while i_ready high.
REQ-008 i_ready  output  1  one-cycle I-side completion pulse.
REQ-009 d_read  input  1  D-cache fill request, held until d_ready.
REQ-010 d_write  input  1  D-cache write-back request, held until d_ready.
REQ-011 d_addr  input  ADDR_W  D-cache line address.
REQ-012 d_wdata  input  LINE_W  D-cache write-back data.
REQ-013 d_rdata  output  LINE_W  D-cache fill data, valid while d_ready high.
REQ-014 d_ready  output  1  one-cycle D-side completion pulse.
REQ-015 mem_read  output  1  memory read command.
REQ-016 mem_write  output  1  memory write command.
REQ-017 mem_addr  output  ADDR_W  memory line address.
REQ-018 mem_wdata  output  LINE_W  memory write data.
REQ-019 mem_rdata  input  LINE_W  memory read data, valid with mem_ready.
REQ-020 mem_ready  input  1  memory completion, may arrive after any latency >= 1 cycle.

Function
REQ-021 The FSM SHALL have states IDLE, I_BUSY, D_BUSY, DONE.
REQ-022 IDLE: no request -> stay; only I request -> I_BUSY; only D request (d_read or d_write) -> D_BUSY.
REQ-023 IDLE with simultaneous I and D requests SHALL grant the side not granted last (round-robin via 1-bit last_grant register).
REQ-024 On grant, the arbiter SHALL latch address, operation and write data into internal registers; mem_* SHALL be driven only from these registers.
REQ-025 mem_read/mem_write SHALL be high from the cycle after grant until the cycle mem_ready is sampled high, inclusive; mem_addr/mem_wdata stable throughout.
REQ-026 d_read and d_write both high SHALL be serviced as a write.
REQ-027 I_BUSY/D_BUSY with mem_ready high SHALL latch mem_rdata into the granted side's rdata register (reads only), update last_grant, go to DONE.
REQ-028 DONE SHALL assert exactly one of i_ready/d_ready for one cycle, then return to IDLE; requests are ignored in DONE.
REQ-029 Latency: request sampled at edge k -> mem command visible in cycle k+1; mem_ready sampled at edge m -> x_ready high in cycle m+1; next grant earliest at edge m+2.
REQ-030 mem_ready while in IDLE or DONE SHALL be ignored.
REQ-031 i_rdata/d_rdata SHALL hold their last value until overwritten by a later fill on the same side.
REQ-032 A request dropped by its requester while in BUSY SHALL NOT abort the memory transaction; completion pulse still issued.
REQ-033 mem_read and mem_write SHALL never be high in the same cycle.

Reset
REQ-034 rst low SHALL immediately force state IDLE, all mem_* commands 0, i_ready/d_ready 0, rdata registers 0, mem_addr/mem_wdata 0.
REQ-035 last_grant SHALL reset to D, so the first tie grants I.
REQ-036 Reset mid-transaction SHALL abandon the transaction with no ready pulse after release.

Structure
REQ-037 Package mem_arb_pkg SHALL hold the state enumeration, ADDR_W/LINE_W defaults and GRANT_I/GRANT_D constants.
REQ-038 No sub-module is needed; the round-robin pick is inline logic.

Verification
REQ-039 I only: i_read, i_addr=0x0000010, memory ready after 3 cycles with rdata 0x...1234 -> mem_read high 3 cycles, mem_addr=0x10, i_ready one cycle with i_rdata=0x...1234.
REQ-040 D write: d_write, d_addr=0x20, d_wdata=0xABCD -> mem_write with mem_wdata=0xABCD, d_ready one cycle, d_rdata unchanged.
REQ-041 Tie after reset: i_read and d_read same cycle, held -> I served first, then D; next tie after that serves I again only after a D grant (alternation I,D,I,D).
REQ-042 d_read and d_write together -> mem_write only, mem_read stays 0.
REQ-043 rst asserted while D_BUSY awaiting mem_ready -> all outputs 0 same cycle, no d_ready after release, late mem_ready ignored.
REQ-044 Back-to-back: I request held continuously over 3 fills with mem latency 1 -> grants spaced 3 cycles, exactly 3 i_ready pulses.
